cache_port_arb: RTL and testbench
=================================

// Module: cache_port_arb
// PURPOSE
//  Two-requester arbiter in front of the cache controller's single upstream port (p0).
//  Shares it between r0 (instruction fetch) and r1 (load/store); round-robin by default.
//  Tracks outstanding reads in an in-order ID FIFO and routes each cache read response
//  back to the requester that issued it.
// PARAMETERS
//  DEPTH   4   max outstanding reads; power of 2, >= 2
// PORTS
//  clk            in   1    clock
//  reset          in   1    synchronous, active-high reset
//  rN_uvld_i      in   1    request valid, N in {0,1}
//  rN_urdy_o      out  1    request accepted this cycle when vld&rdy
//  rN_addr_i      in   32   request address
//  rN_web_i       in   1    0 = write, 1 = read
//  rN_wdat_i      in   32   write data
//  rN_wmask_i     in   4    write byte mask
//  rN_dvld_o      out  1    read response valid
//  rN_drdy_i      in   1    read response ready
//  rN_ddat_o      out  32   read response data
//  c_uvld_o       out  1    to cache p0_uvld_i
//  c_urdy_i       in   1    from cache p0_urdy_o
//  c_addr_o       out  32   to cache; also c_web_o[1], c_wdat_o[32], c_wmask_o[4]
//  c_dvld_i       in   1    from cache p0_dvld_o
//  c_drdy_o       out  1    to cache p0_drdy_i
//  c_ddat_i       in   32   from cache p0_ddat_o
//  err_o          out  1    sticky: response arrived with no read outstanding
// BEHAVIOUR
//  Reset: FIFO empty, count=0, rr pointer favours r0, lock clear, err_o=0;
//   all *_urdy_o, *_dvld_o, c_uvld_o, c_drdy_o = 0 while reset is high.
//  Eligible(N): rN_uvld_i && (rN_web_i==0 || count<DEPTH). Reads need a free FIFO slot.
//  Grant: if lock set, the locked requester; else the eligible requester, and if both are
//   eligible, the one favoured by rr. Zero added latency: c_* = mux(granted rN_*).
//  c_uvld_o = granted requester is eligible; rG_urdy_o = c_urdy_i; the other urdy is 0.
//  Lock FSM: UNLOCKED -> LOCKED when c_uvld_o && !c_urdy_i (grant held stable);
//   LOCKED -> UNLOCKED on c_uvld_o && c_urdy_i. Requesters must hold request until accepted.
//  rr update on each accepted transfer: favour the non-granted requester next.
//  Accepted read (web=1): push grant ID (1 bit) into FIFO. Writes push nothing.
//  Response: head ID H selects the path: rH_dvld_o = c_dvld_i && !empty,
//   rH_ddat_o = c_ddat_i, c_drdy_o = rH_drdy_i && !empty; the other dvld = 0.
//  Pop on c_dvld_i && c_drdy_o. Push and pop in the same cycle: count unchanged.
//   Full with simultaneous pop: the new read is still refused (no bypass of the full check).
//  c_dvld_i while empty: response dropped, c_drdy_o=0, err_o set until reset.
//  Pointers wrap mod DEPTH; count width = $clog2(DEPTH)+1; count never exceeds DEPTH.
//  Reset mid-operation: all outstanding IDs are discarded; in-flight cache responses
//   after reset raise err_o.
// CONFIGURATION
//  CACHE_ARB_DPRIO_EN defined: r1 (data) has strict priority over r0 when both are eligible;
//   the rr pointer is removed. Lock behaviour is unchanged, so r0 is never preempted
//   once it is presented.
//  Undefined (default): round-robin as described above.
// TESTING
//  1. Both assert reads every cycle, c_urdy_i=1, DEPTH=4 -> grants r0,r1,r0,r1;
//     count=4, then both urdy_o=0.
//  2. r0 read presented, c_urdy_i=0 for 3 cycles, r1 read asserted in cycle 2 ->
//     c_* stays on r0 (addr held); r1 is granted next cycle after acceptance.
//  3. Issue r1 read A=0x100, r0 read A=0x200; cache returns 0xAAAA then 0xBBBB ->
//     r1_ddat_o=0xAAAA, then r0_ddat_o=0xBBBB.
//  4. FIFO full (4 reads); r0 write + r1 read pending -> write accepted, read stalls;
//     one pop -> read accepted on the following cycle.
//  5. Head=r0, r0_drdy_i=0 for 2 cycles with c_dvld_i=1 -> c_drdy_o=0; no pop and no
//     r1_dvld_o until r0_drdy_i=1.
//  6. c_dvld_i=1 with FIFO empty -> err_o=1 the next cycle and held; reset clears it.
//     Also repeat test 1 with CACHE_ARB_DPRIO_EN defined -> r1 is granted every cycle.

Source files
------------

// File: rtl/cache_port_arb.sv
// Two-requester arbiter for the cache upstream port with in-order read-response routing.
// Optional build macro CACHE_ARB_DPRIO_EN: r1 gets strict priority instead of round-robin.
module cache_port_arb #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_uvld_i,
  output logic        r0_urdy_o,
  input  logic [31:0] r0_addr_i,
  input  logic        r0_web_i,
  input  logic [31:0] r0_wdat_i,
  input  logic [3:0]  r0_wmask_i,
  output logic        r0_dvld_o,
  input  logic        r0_drdy_i,
  output logic [31:0] r0_ddat_o,
  input  logic        r1_uvld_i,
  output logic        r1_urdy_o,
  input  logic [31:0] r1_addr_i,
  input  logic        r1_web_i,
  input  logic [31:0] r1_wdat_i,
  input  logic [3:0]  r1_wmask_i,
  output logic        r1_dvld_o,
  input  logic        r1_drdy_i,
  output logic [31:0] r1_ddat_o,
  output logic        c_uvld_o,
  input  logic        c_urdy_i,
  output logic [31:0] c_addr_o,
  output logic        c_web_o,
  output logic [31:0] c_wdat_o,
  output logic [3:0]  c_wmask_o,
  input  logic        c_dvld_i,
  output logic        c_drdy_o,
  input  logic [31:0] c_ddat_i,
  output logic        err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t      lock_state_r;
  lock_state_t      lock_state_s;
  logic             lock_id_r;
  logic             lock_id_s;
  logic [DEPTH-1:0] id_fifo_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             err_r;

  logic not_full_s;
  logic elig0_s;
  logic elig1_s;
  logic gnt_s;
  logic req_vld_s;
  logic accept_s;
  logic push_s;
  logic pop_s;
  logic empty_s;
  logic head_s;

  assign not_full_s = (count_r < DEPTH_C);
  assign empty_s    = (count_r == {CW{1'b0}});
  assign head_s     = id_fifo_r[rd_ptr_r];

  // A read may only be presented while an ID slot is free; writes are never throttled.
  assign elig0_s = r0_uvld_i && (!r0_web_i || not_full_s);
  assign elig1_s = r1_uvld_i && (!r1_web_i || not_full_s);

`ifdef CACHE_ARB_DPRIO_EN
  // grant selection: lock wins, then strict r1 priority
  always_comb begin
    gnt_s = 1'b0;
    if (lock_state_r == LOCKED) begin
      gnt_s = lock_id_r;
    end else if (elig1_s) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end
`else
  logic rr_r;

  // grant selection: lock wins, then round-robin on contention
  always_comb begin
    gnt_s = 1'b0;
    if (lock_state_r == LOCKED) begin
      gnt_s = lock_id_r;
    end else if (elig0_s && elig1_s) begin
      gnt_s = rr_r;
    end else if (elig1_s) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end

  // round-robin pointer: favour the other requester after each accepted transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_r <= 1'b0;
    end else if (accept_s) begin
      rr_r <= ~gnt_s;
    end else begin
      rr_r <= rr_r;
    end
  end
`endif

  // Request path is a pure mux so no cycle is added between requester and cache.
  assign req_vld_s = gnt_s ? elig1_s : elig0_s;
  assign c_uvld_o  = req_vld_s && !reset;
  assign c_addr_o  = gnt_s ? r1_addr_i  : r0_addr_i;
  assign c_web_o   = gnt_s ? r1_web_i   : r0_web_i;
  assign c_wdat_o  = gnt_s ? r1_wdat_i  : r0_wdat_i;
  assign c_wmask_o = gnt_s ? r1_wmask_i : r0_wmask_i;

  assign accept_s  = c_uvld_o && c_urdy_i;
  assign r0_urdy_o = accept_s && !gnt_s;
  assign r1_urdy_o = accept_s && gnt_s;
  assign push_s    = accept_s && c_web_o;

  // Response path steered by the oldest outstanding ID.
  assign c_drdy_o  = !reset && !empty_s && (head_s ? r1_drdy_i : r0_drdy_i);
  assign r0_dvld_o = !reset && c_dvld_i && !empty_s && !head_s;
  assign r1_dvld_o = !reset && c_dvld_i && !empty_s && head_s;
  assign r0_ddat_o = head_s ? 32'h0000_0000 : c_ddat_i;
  assign r1_ddat_o = head_s ? c_ddat_i : 32'h0000_0000;
  assign pop_s     = c_dvld_i && c_drdy_o;
  assign err_o     = err_r;

  // lock FSM next state: hold the grant while the cache stalls a presented request
  always_comb begin
    lock_state_s = lock_state_r;
    lock_id_s    = lock_id_r;
    case (lock_state_r)
      UNLOCKED: begin
        if (c_uvld_o && !c_urdy_i) begin
          lock_state_s = LOCKED;
          lock_id_s    = gnt_s;
        end else begin
          lock_state_s = UNLOCKED;
        end
      end
      LOCKED: begin
        if (accept_s) begin
          lock_state_s = UNLOCKED;
        end else begin
          lock_state_s = LOCKED;
        end
      end
      default: begin
        lock_state_s = UNLOCKED;
        lock_id_s    = 1'b0;
      end
    endcase
  end

  // lock FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state_r <= UNLOCKED;
      lock_id_r    <= 1'b0;
    end else begin
      lock_state_r <= lock_state_s;
      lock_id_r    <= lock_id_s;
    end
  end

  // in-order ID FIFO; a full FIFO refuses reads even when a pop coincides
  always_ff @(posedge clk) begin
    if (reset) begin
      id_fifo_r <= {DEPTH{1'b0}};
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        id_fifo_r[wr_ptr_r] <= gnt_s;
        wr_ptr_r            <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // sticky error for a response with nothing outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (c_dvld_i && empty_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_cache_port_arb.sv
// Directed self-checking bench for cache_port_arb (DEPTH=4); honours CACHE_ARB_DPRIO_EN.
module tb_cache_port_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_uvld, r0_urdy, r0_web, r0_dvld, r0_drdy;
  logic [31:0] r0_addr, r0_wdat, r0_ddat;
  logic [3:0]  r0_wmask;
  logic        r1_uvld, r1_urdy, r1_web, r1_dvld, r1_drdy;
  logic [31:0] r1_addr, r1_wdat, r1_ddat;
  logic [3:0]  r1_wmask;
  logic        c_uvld, c_urdy, c_web, c_dvld, c_drdy, err;
  logic [31:0] c_addr, c_wdat, c_ddat;
  logic [3:0]  c_wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_port_arb #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .r0_uvld_i(r0_uvld), .r0_urdy_o(r0_urdy), .r0_addr_i(r0_addr), .r0_web_i(r0_web),
    .r0_wdat_i(r0_wdat), .r0_wmask_i(r0_wmask), .r0_dvld_o(r0_dvld), .r0_drdy_i(r0_drdy),
    .r0_ddat_o(r0_ddat),
    .r1_uvld_i(r1_uvld), .r1_urdy_o(r1_urdy), .r1_addr_i(r1_addr), .r1_web_i(r1_web),
    .r1_wdat_i(r1_wdat), .r1_wmask_i(r1_wmask), .r1_dvld_o(r1_dvld), .r1_drdy_i(r1_drdy),
    .r1_ddat_o(r1_ddat),
    .c_uvld_o(c_uvld), .c_urdy_i(c_urdy), .c_addr_o(c_addr), .c_web_o(c_web),
    .c_wdat_o(c_wdat), .c_wmask_o(c_wmask), .c_dvld_i(c_dvld), .c_drdy_o(c_drdy),
    .c_ddat_i(c_ddat), .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    r0_uvld = 1'b0; r0_addr = 32'h0; r0_web = 1'b1; r0_wdat = 32'h0; r0_wmask = 4'h0;
    r1_uvld = 1'b0; r1_addr = 32'h0; r1_web = 1'b1; r1_wdat = 32'h0; r1_wmask = 4'h0;
    r0_drdy = 1'b1; r1_drdy = 1'b1;
    c_urdy = 1'b1; c_dvld = 1'b0; c_ddat = 32'h0;
  endtask

  initial begin
    logic [3:0] exp_g;
    logic       g;

    // reset: outputs gated even with live inputs
    idle();
    reset = 1'b1;
    r0_uvld = 1'b1; r1_uvld = 1'b1; c_dvld = 1'b1;
    #1;
    chk("rst_c_uvld", c_uvld, 1'b0);
    chk("rst_r0_urdy", r0_urdy, 1'b0);
    chk("rst_r1_urdy", r1_urdy, 1'b0);
    chk("rst_c_drdy", c_drdy, 1'b0);
    chk("rst_r0_dvld", r0_dvld, 1'b0);
    tick(); tick();
    chk("rst_err", err, 1'b0);
    idle();
    reset = 1'b0;
    tick();

    // test 1: both read every cycle until the FIFO is full
`ifdef CACHE_ARB_DPRIO_EN
    exp_g = 4'b1111;
`else
    exp_g = 4'b1010;
`endif
    r0_uvld = 1'b1; r0_addr = 32'h10;
    r1_uvld = 1'b1; r1_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      g = exp_g[i];
      #1;
      chk("t1_addr", c_addr, g ? 32'h20 : 32'h10);
      chk("t1_r0_urdy", r0_urdy, !g);
      chk("t1_r1_urdy", r1_urdy, g);
      tick();
    end
    #1;
    chk("t1_full_uvld", c_uvld, 1'b0);
    chk("t1_full_r0_urdy", r0_urdy, 1'b0);
    chk("t1_full_r1_urdy", r1_urdy, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) begin
      g = exp_g[i];
      c_dvld = 1'b1; c_ddat = 32'hD0 + i;
      #1;
      chk("t1_r0_dvld", r0_dvld, !g);
      chk("t1_r1_dvld", r1_dvld, g);
      chk("t1_ddat", g ? r1_ddat : r0_ddat, 32'hD0 + i);
      tick();
    end
    c_dvld = 1'b0;

    // test 2: stalled r0 request holds the port against r1
    r0_uvld = 1'b1; r0_addr = 32'h200; c_urdy = 1'b0;
    #1;
    chk("t2_uvld", c_uvld, 1'b1);
    chk("t2_addr_a", c_addr, 32'h200);
    chk("t2_r0_urdy_a", r0_urdy, 1'b0);
    tick();
    r1_uvld = 1'b1; r1_addr = 32'h300;
    #1;
    chk("t2_addr_b", c_addr, 32'h200);
    chk("t2_r1_urdy_b", r1_urdy, 1'b0);
    tick();
    #1;
    chk("t2_addr_c", c_addr, 32'h200);
    tick();
    c_urdy = 1'b1;
    #1;
    chk("t2_r0_urdy_d", r0_urdy, 1'b1);
    chk("t2_addr_d", c_addr, 32'h200);
    tick();
    r0_uvld = 1'b0;
    #1;
    chk("t2_addr_r1", c_addr, 32'h300);
    chk("t2_r1_urdy", r1_urdy, 1'b1);
    tick();
    idle();
    c_dvld = 1'b1; c_ddat = 32'h1111;
    #1;
    chk("t2_rsp0", r0_dvld, 1'b1);
    chk("t2_rsp0_dat", r0_ddat, 32'h1111);
    tick();
    c_ddat = 32'h2222;
    #1;
    chk("t2_rsp1", r1_dvld, 1'b1);
    chk("t2_rsp1_r0", r0_dvld, 1'b0);
    tick();
    c_dvld = 1'b0;

    // test 3: responses routed in issue order
    r1_uvld = 1'b1; r1_addr = 32'h100;
    #1;
    chk("t3_r1_urdy", r1_urdy, 1'b1);
    tick();
    r1_uvld = 1'b0; r0_uvld = 1'b1; r0_addr = 32'h200;
    #1;
    chk("t3_r0_urdy", r0_urdy, 1'b1);
    chk("t3_addr", c_addr, 32'h200);
    tick();
    idle();
    c_dvld = 1'b1; c_ddat = 32'hAAAA;
    #1;
    chk("t3_r1_dvld", r1_dvld, 1'b1);
    chk("t3_r1_ddat", r1_ddat, 32'hAAAA);
    chk("t3_r0_dvld", r0_dvld, 1'b0);
    tick();

    // test 5: head r0 back-pressures the cache; nothing leaks to r1
    c_ddat = 32'hBBBB; r0_drdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t5_c_drdy", c_drdy, 1'b0);
      chk("t5_r0_dvld", r0_dvld, 1'b1);
      chk("t5_r1_dvld", r1_dvld, 1'b0);
      tick();
    end
    r0_drdy = 1'b1;
    #1;
    chk("t5_c_drdy_go", c_drdy, 1'b1);
    chk("t5_r0_ddat", r0_ddat, 32'hBBBB);
    tick();
    c_dvld = 1'b0;
    #1;
    chk("t5_empty_drdy", c_drdy, 1'b0);

    // test 4: full FIFO admits a write but stalls a read until a pop
    r0_uvld = 1'b1; r0_addr = 32'h40;
    for (int i = 0; i < 4; i++) tick();
    r0_web = 1'b0; r0_addr = 32'h44; r0_wdat = 32'hCAFE_F00D; r0_wmask = 4'hA;
    r1_uvld = 1'b1; r1_addr = 32'h88;
    #1;
    chk("t4_wr_urdy", r0_urdy, 1'b1);
    chk("t4_wr_web", c_web, 1'b0);
    chk("t4_wr_wdat", c_wdat, 32'hCAFE_F00D);
    chk("t4_wr_wmask", c_wmask, 4'hA);
    chk("t4_rd_stall", r1_urdy, 1'b0);
    tick();
    r0_uvld = 1'b0; r0_web = 1'b1;
    c_dvld = 1'b1; c_ddat = 32'h4;
    #1;
    chk("t4_pop_uvld", c_uvld, 1'b0);
    chk("t4_pop_r1_urdy", r1_urdy, 1'b0);
    chk("t4_pop_drdy", c_drdy, 1'b1);
    tick();
    c_dvld = 1'b0;
    #1;
    chk("t4_rd_uvld", c_uvld, 1'b1);
    chk("t4_rd_urdy", r1_urdy, 1'b1);
    chk("t4_rd_addr", c_addr, 32'h88);
    tick();
    idle();
    exp_g = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      g = exp_g[i];
      c_dvld = 1'b1;
      #1;
      chk("t4_drain", r1_dvld, g);
      tick();
    end
    c_dvld = 1'b0;

    // test 6: orphan response sets sticky error; reset clears it
    c_dvld = 1'b1; c_ddat = 32'hDEAD;
    #1;
    chk("t6_drdy", c_drdy, 1'b0);
    chk("t6_dvld", r0_dvld, 1'b0);
    tick();
    c_dvld = 1'b0;
    chk("t6_err_set", err, 1'b1);
    tick();
    chk("t6_err_held", err, 1'b1);
    reset = 1'b1;
    tick();
    chk("t6_err_clr", err, 1'b0);
    reset = 1'b0;

    // reset mid-operation discards outstanding IDs
    r0_uvld = 1'b1; r0_addr = 32'h500;
    tick();
    r0_uvld = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    c_dvld = 1'b1;
    #1;
    chk("rst_mid_dvld", r0_dvld, 1'b0);
    tick();
    c_dvld = 1'b0;
    chk("rst_mid_err", err, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
